fork_type: RTL and testbench

- Eager fork for the dataflow handshake.
- Takes one valid/ready input token and delivers it to SIZE output channels, each completing independently.
- Counterpart of the join in front of arithmetic units such as the float adder/subtractor: join merges operand handshakes into one, fork_type splits one result handshake into many consumers.
- Sits between a unit's result port and all of that result's users.

---
 rtl/fork_type_pkg.sv | 16 +
 rtl/fork_branch.sv | 69 ++++++
 rtl/fork_type.sv | 46 ++++
 tb/tb_fork_type.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fork_type_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fork_type_pkg : shared constants and helpers for the eager fork    |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
package fork_type_pkg;

  localparam int unsigned FORK_SIZE_MIN = 2;

  // A channel no longer blocks the token once it took it or takes it now.
  function automatic logic branch_done(input logic sent, input logic ready);
    return sent | ready;
  endfunction

endpackage : fork_type_pkg
`default_nettype wire

// File: rtl/fork_branch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fork_branch : one output channel of fork_type (sent flag, valid    |
// |               gating, done term; optional FORK_OEHB_EN stage)      |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module fork_branch
  import fork_type_pkg::*;
#(
  parameter int DATA_TYPE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] ins_i,
  input  logic                 ins_valid_i,
  input  logic                 complete_i,
  output logic [DATA_TYPE-1:0] outs_o,
  output logic                 outs_valid_o,
  input  logic                 outs_ready_i,
  output logic                 done_o
);

  logic sent_q;
  logic sent_d;
  logic w_sent;
  logic w_fork_valid;
  logic w_fork_ready;

  // Masking with rst makes the reset-time outputs independent of the flag.
  assign w_sent       = sent_q & rst;
  assign w_fork_valid = ins_valid_i & ~w_sent;
  assign done_o       = branch_done(w_sent, w_fork_ready);

  always_comb begin
    sent_d = sent_q | (w_fork_valid & w_fork_ready);
    if (complete_i) sent_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) sent_q <= 1'b0;
    else      sent_q <= sent_d;
  end

`ifdef FORK_OEHB_EN
  logic                 valid_q;
  logic [DATA_TYPE-1:0] data_q;

  assign w_fork_ready = ~valid_q | outs_ready_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (w_fork_ready) begin
      valid_q <= w_fork_valid;
      if (w_fork_valid) data_q <= ins_i;
    end
  end

  assign outs_o       = data_q;
  assign outs_valid_o = valid_q & rst;
`else
  assign w_fork_ready = outs_ready_i;
  assign outs_o       = ins_i;
  assign outs_valid_o = w_fork_valid;
`endif

endmodule : fork_branch
`default_nettype wire

// File: rtl/fork_type.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fork_type : eager fork, one valid/ready token to SIZE channels.    |
// |             Define FORK_OEHB_EN for a registered output per lane.  |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module fork_type
  import fork_type_pkg::*;
#(
  parameter int SIZE      = 2,
  parameter int DATA_TYPE = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_TYPE-1:0]      ins,
  input  logic                      ins_valid,
  output logic                      ins_ready,
  output logic [SIZE*DATA_TYPE-1:0] outs,
  output logic [SIZE-1:0]           outs_valid,
  input  logic [SIZE-1:0]           outs_ready
);

  logic [SIZE-1:0] w_done;
  logic            w_complete;

  assign ins_ready  = &w_done;
  assign w_complete = ins_valid & ins_ready;

  for (genvar i = 0; i < SIZE; i++) begin : g_branch
    fork_branch #(
      .DATA_TYPE (DATA_TYPE)
    ) u_branch (
      .clk          (clk),
      .rst          (rst),
      .ins_i        (ins),
      .ins_valid_i  (ins_valid),
      .complete_i   (w_complete),
      .outs_o       (outs[i*DATA_TYPE +: DATA_TYPE]),
      .outs_valid_o (outs_valid[i]),
      .outs_ready_i (outs_ready[i]),
      .done_o       (w_done[i])
    );
  end

endmodule : fork_type
`default_nettype wire

// File: tb/tb_fork_type.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fork_type : directed self-checking bench for fork_type (SIZE 2  |
// |                and 3); FORK_OEHB_EN selects the registered checks. |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module tb_fork_type;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins2, ins3;
  logic        ins_valid2, ins_valid3;
  logic        ins_ready2, ins_ready3;
  logic [63:0] outs2;
  logic [95:0] outs3;
  logic [1:0]  outs_valid2, outs_ready2;
  logic [2:0]  outs_valid3, outs_ready3;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fork_type #(.SIZE(2), .DATA_TYPE(32)) d2 (
    .clk(clk), .rst(rst), .ins(ins2), .ins_valid(ins_valid2), .ins_ready(ins_ready2),
    .outs(outs2), .outs_valid(outs_valid2), .outs_ready(outs_ready2)
  );

  fork_type #(.SIZE(3), .DATA_TYPE(32)) d3 (
    .clk(clk), .rst(rst), .ins(ins3), .ins_valid(ins_valid3), .ins_ready(ins_ready3),
    .outs(outs3), .outs_valid(outs_valid3), .outs_ready(outs_ready3)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after a rising edge; checks happen 2 units later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  initial begin
    rst = 1'b0;
    ins2 = '0; ins3 = '0;
    ins_valid2 = 1'b0; ins_valid3 = 1'b0;
    outs_ready2 = 2'b00; outs_ready3 = 3'b000;
    #1;
    settle;
    chk("reset_valid_idle", {94'd0, outs_valid2}, 96'd0);
    chk("reset_ready_idle", {95'd0, ins_ready2}, 96'd0);
    ins_valid2 = 1'b1; outs_ready2 = 2'b11;
    settle;
`ifdef FORK_OEHB_EN
    chk("reset_valid_reg", {94'd0, outs_valid2}, 96'd0);
`else
    chk("reset_valid_comb", {94'd0, outs_valid2}, 96'd3);
`endif
    tick; tick;
    ins_valid2 = 1'b0;
    rst = 1'b1;

`ifdef FORK_OEHB_EN
    ins2 = 32'd7; ins_valid2 = 1'b1; outs_ready2 = 2'b11;
    settle;
    chk("oehb_no_comb_valid", {94'd0, outs_valid2}, 96'd0);
    chk("oehb_ins_ready", {95'd0, ins_ready2}, 96'd1);
    for (int v = 1; v <= 3; v++) begin
      tick;
      ins2 = 32'(v);
      settle;
      chk("oehb_valid", {94'd0, outs_valid2}, 96'd3);
      chk("oehb_data", {32'd0, outs2}, {32'd0, {2{32'(v == 1 ? 7 : v - 1)}}});
      chk("oehb_tput", {95'd0, ins_ready2}, 96'd1);
    end
    ins_valid2 = 1'b0;
    tick;
    settle;
    chk("oehb_last", {32'd0, outs2}, {32'd0, {2{32'd3}}});
    tick;
    settle;
    chk("oehb_drain", {94'd0, outs_valid2}, 96'd0);
    ins2 = 32'd9; ins_valid2 = 1'b1; outs_ready2 = 2'b00;
    tick;
    settle;
    chk("oehb_held", {94'd0, outs_valid2}, 96'd3);
    rst = 1'b0;
    ins_valid2 = 1'b0;
    tick;
    settle;
    chk("oehb_reset_valid", {94'd0, outs_valid2}, 96'd0);
    chk("oehb_reset_data", {32'd0, outs2}, 96'd0);
    rst = 1'b1;
`else
    ins2 = 32'h3F80_0000; ins_valid2 = 1'b1; outs_ready2 = 2'b11;
    settle;
    chk("all_ready_data", {32'd0, outs2}, {32'd0, {2{32'h3F80_0000}}});
    chk("all_ready_valid", {94'd0, outs_valid2}, 96'd3);
    chk("all_ready_ins_ready", {95'd0, ins_ready2}, 96'd1);
    tick;
    ins2 = 32'h4000_0000; outs_ready2 = 2'b01;
    settle;
    chk("split0_valid", {94'd0, outs_valid2}, 96'd3);
    chk("split0_ins_ready", {95'd0, ins_ready2}, 96'd0);
    tick;
    outs_ready2 = 2'b10;
    settle;
    chk("split1_valid", {94'd0, outs_valid2}, 96'd2);
    chk("split1_ins_ready", {95'd0, ins_ready2}, 96'd1);
    chk("split1_data", {64'd0, outs2[63:32]}, {64'd0, 32'h4000_0000});
    tick;
    ins_valid2 = 1'b0; outs_ready2 = 2'b00;
    settle;
    chk("split_cleared", {94'd0, outs_valid2}, 96'd0);
    tick;

    for (int v = 1; v <= 3; v++) begin
      ins2 = 32'(v); ins_valid2 = 1'b1; outs_ready2 = 2'b11;
      settle;
      chk("b2b_ready", {95'd0, ins_ready2}, 96'd1);
      chk("b2b_valid", {94'd0, outs_valid2}, 96'd3);
      chk("b2b_data", {32'd0, outs2}, {32'd0, {2{32'(v)}}});
      tick;
    end

    ins2 = 32'hA5; ins_valid2 = 1'b1; outs_ready2 = 2'b01;
    tick;
    outs_ready2 = 2'b00;
    settle;
    chk("rst_mid_before", {94'd0, outs_valid2}, 96'd2);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    settle;
    chk("rst_mid_reoffer", {94'd0, outs_valid2}, 96'd3);
    chk("rst_mid_data0", {64'd0, outs2[31:0]}, 96'hA5);
    chk("rst_mid_ins_ready", {95'd0, ins_ready2}, 96'd0);
    ins_valid2 = 1'b0;
    tick;

    ins3 = 32'hDEAD; ins_valid3 = 1'b1; outs_ready3 = 3'b000;
    for (int c = 0; c < 5; c++) begin
      settle;
      chk("s3_hold_valid", {93'd0, outs_valid3}, 96'd7);
      chk("s3_hold_ready", {95'd0, ins_ready3}, 96'd0);
      tick;
    end
    outs_ready3 = 3'b111;
    settle;
    chk("s3_release_ready", {95'd0, ins_ready3}, 96'd1);
    chk("s3_release_data", outs3, {3{32'hDEAD}});
    tick;
    outs_ready3 = 3'b010;
    settle;
    chk("s3_fresh_valid", {93'd0, outs_valid3}, 96'd7);
    tick;
    settle;
    chk("s3_part_valid", {93'd0, outs_valid3}, 96'd5);
    ins_valid3 = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_fork_type
`default_nettype wire
